// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit.
package mips_multicycle_ctrl_pkg;

    // Controller states; numeric values are visible on the debug port.
    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_R   = 4'd2,
        ST_EXEC_I   = 4'd3,
        ST_MEM_ADDR = 4'd4,
        ST_MEM_RD   = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_WB_ALU   = 4'd7,
        ST_WB_MEM   = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_TRAP     = 4'd10
    } state_e;

    // Instruction class captured in DECODE and used by later states.
    typedef enum logic [3:0] {
        CLS_INVALID,
        CLS_RTYPE,
        CLS_ADDI,
        CLS_SLTI,
        CLS_ANDI,
        CLS_ORI,
        CLS_LW,
        CLS_SW,
        CLS_BEQ,
        CLS_BNE,
        CLS_J
    } cls_e;

    // Opcodes
    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_BNE   = 6'h05;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_SLTI  = 6'h0A;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    // R-type function codes
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALU operation codes
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // PC source select
    localparam logic [1:0] PCSRC_PC4    = 2'd0;
    localparam logic [1:0] PCSRC_BRANCH = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    // ALU B operand select
    localparam logic [1:0] ALUB_RT   = 2'd0;
    localparam logic [1:0] ALUB_FOUR = 2'd1;
    localparam logic [1:0] ALUB_IMM  = 2'd2;
    localparam logic [1:0] ALUB_BOFF = 2'd3;

    // Register file write data select
    localparam logic [1:0] RFWD_ALU = 2'd0;
    localparam logic [1:0] RFWD_MEM = 2'd1;

    // Map opcode/function to an instruction class; unsupported encodings give CLS_INVALID.
    function automatic cls_e classify(input logic [5:0] opc, input logic [5:0] func);
        cls_e c;
        c = CLS_INVALID;
        case (opc)
            OPC_RTYPE: begin
                case (func)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: c = CLS_RTYPE;
                    default:                                c = CLS_INVALID;
                endcase
            end
            OPC_J:    c = CLS_J;
            OPC_BEQ:  c = CLS_BEQ;
            OPC_BNE:  c = CLS_BNE;
            OPC_ADDI: c = CLS_ADDI;
            OPC_SLTI: c = CLS_SLTI;
            OPC_ANDI: c = CLS_ANDI;
            OPC_ORI:  c = CLS_ORI;
            OPC_LW:   c = CLS_LW;
            OPC_SW:   c = CLS_SW;
            default:  c = CLS_INVALID;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// ALU operation decode from the registered instruction class and function field.
module mips_alu_decoder
    import mips_multicycle_ctrl_pkg::*;
#(
    parameter int unsigned ALU_FUNC_W = 3
) (
    input  cls_e                  cls,
    input  logic [5:0]            func,
    output logic [ALU_FUNC_W-1:0] alu_func
);

    logic [2:0] code;

    // Select the ALU operation the instruction class calls for.
    always_comb begin
        code = ALU_ADD;
        case (cls)
            CLS_RTYPE: begin
                case (func)
                    FN_ADD:  code = ALU_ADD;
                    FN_SUB:  code = ALU_SUB;
                    FN_AND:  code = ALU_AND;
                    FN_OR:   code = ALU_OR;
                    FN_SLT:  code = ALU_SLT;
                    default: code = ALU_ADD;
                endcase
            end
            CLS_ADDI, CLS_LW, CLS_SW: code = ALU_ADD;
            CLS_SLTI:                 code = ALU_SLT;
            CLS_ANDI:                 code = ALU_AND;
            CLS_ORI:                  code = ALU_OR;
            CLS_BEQ, CLS_BNE:         code = ALU_SUB;
            default:                  code = ALU_ADD;
        endcase
    end

    assign alu_func = ALU_FUNC_W'(code);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: fetch/decode/execute/memory/write-back sequencing,
// memory ready handshake with timeout, and sticky trap on invalid instruction or bus fault.
module mips_multicycle_ctrl
    import mips_multicycle_ctrl_pkg::*;
#(
    parameter int unsigned ALU_FUNC_W  = 3,
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [5:0]            opc,
    input  logic [5:0]            func,
    input  logic                  memReady,
    output logic                  irWrite,
    output logic                  pcWrite,
    output logic [1:0]            pcSrc,
    output logic                  iord,
    output logic                  isJmp,
    output logic                  isBeq,
    output logic                  isBne,
    output logic [1:0]            rfWriteDataSel,
    output logic                  rfWriteAddrSel,
    output logic                  rfWriteEnable,
    output logic                  memRead,
    output logic                  memWrite,
    output logic                  aluSrcA,
    output logic [1:0]            aluSrcB,
    output logic [ALU_FUNC_W-1:0] aluFunc,
    output logic                  bitXtend,
    output logic                  invOpcode,
    output logic                  busError,
    output logic [3:0]            state
);

    state_e           state_q, state_d;
    cls_e             cls_q, cls_d;
    logic [5:0]       func_q, func_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             inv_q, inv_d;
    logic             bus_q, bus_d;

    cls_e                  dec_cls;
    logic [ALU_FUNC_W-1:0] alu_sel;
    logic [ALU_FUNC_W-1:0] alu_add;
    logic                  timeout;
    logic                  wait_state;

    assign dec_cls    = classify(opc, func);
    assign alu_add    = ALU_FUNC_W'(ALU_ADD);
    assign timeout    = (cnt_q == CNT_W'(MEM_TIMEOUT));
    assign wait_state = (state_q == ST_FETCH) || (state_q == ST_MEM_RD) || (state_q == ST_MEM_WR);

    mips_alu_decoder #(
        .ALU_FUNC_W(ALU_FUNC_W)
    ) u_alu_dec (
        .cls      (cls_q),
        .func     (func_q),
        .alu_func (alu_sel)
    );

    // Next-state, captured fields, sticky flags and per-state control outputs.
    always_comb begin
        state_d        = state_q;
        cls_d          = cls_q;
        func_d         = func_q;
        inv_d          = inv_q;
        bus_d          = bus_q;
        irWrite        = 1'b0;
        pcWrite        = 1'b0;
        pcSrc          = PCSRC_PC4;
        iord           = 1'b0;
        isJmp          = 1'b0;
        isBeq          = 1'b0;
        isBne          = 1'b0;
        rfWriteDataSel = RFWD_ALU;
        rfWriteAddrSel = 1'b0;
        rfWriteEnable  = 1'b0;
        memRead        = 1'b0;
        memWrite       = 1'b0;
        aluSrcA        = 1'b0;
        aluSrcB        = ALUB_RT;
        aluFunc        = '0;
        bitXtend       = 1'b0;

        case (state_q)
            ST_FETCH: begin
                memRead = 1'b1;
                aluSrcB = ALUB_FOUR;
                aluFunc = alu_add;
                if (memReady) begin
                    irWrite = 1'b1;
                    pcWrite = 1'b1;
                    pcSrc   = PCSRC_PC4;
                    state_d = ST_DECODE;
                end else if (timeout) begin
                    bus_d   = 1'b1;
                    state_d = ST_TRAP;
                end
            end
            ST_DECODE: begin
                aluSrcB = ALUB_BOFF;
                aluFunc = alu_add;
                cls_d   = dec_cls;
                func_d  = func;
                case (dec_cls)
                    CLS_RTYPE:                               state_d = ST_EXEC_R;
                    CLS_ADDI, CLS_SLTI, CLS_ANDI, CLS_ORI:   state_d = ST_EXEC_I;
                    CLS_LW, CLS_SW:                          state_d = ST_MEM_ADDR;
                    CLS_BEQ, CLS_BNE:                        state_d = ST_BRANCH;
                    CLS_J: begin
                        pcWrite = 1'b1;
                        pcSrc   = PCSRC_JUMP;
                        isJmp   = 1'b1;
                        state_d = ST_FETCH;
                    end
                    default: begin
                        inv_d   = 1'b1;
                        state_d = ST_TRAP;
                    end
                endcase
            end
            ST_EXEC_R: begin
                aluSrcA = 1'b1;
                aluSrcB = ALUB_RT;
                aluFunc = alu_sel;
                state_d = ST_WB_ALU;
            end
            ST_EXEC_I: begin
                aluSrcA  = 1'b1;
                aluSrcB  = ALUB_IMM;
                aluFunc  = alu_sel;
                bitXtend = (cls_q == CLS_ANDI) || (cls_q == CLS_ORI);
                state_d  = ST_WB_ALU;
            end
            ST_MEM_ADDR: begin
                aluSrcA = 1'b1;
                aluSrcB = ALUB_IMM;
                aluFunc = alu_sel;
                state_d = (cls_q == CLS_LW) ? ST_MEM_RD : ST_MEM_WR;
            end
            ST_MEM_RD: begin
                memRead = 1'b1;
                iord    = 1'b1;
                if (memReady) begin
                    state_d = ST_WB_MEM;
                end else if (timeout) begin
                    bus_d   = 1'b1;
                    state_d = ST_TRAP;
                end
            end
            ST_MEM_WR: begin
                memWrite = 1'b1;
                iord     = 1'b1;
                if (memReady) begin
                    state_d = ST_FETCH;
                end else if (timeout) begin
                    bus_d   = 1'b1;
                    state_d = ST_TRAP;
                end
            end
            ST_WB_ALU: begin
                rfWriteEnable  = 1'b1;
                rfWriteDataSel = RFWD_ALU;
                rfWriteAddrSel = (cls_q == CLS_RTYPE);
                state_d        = ST_FETCH;
            end
            ST_WB_MEM: begin
                rfWriteEnable  = 1'b1;
                rfWriteDataSel = RFWD_MEM;
                rfWriteAddrSel = 1'b0;
                state_d        = ST_FETCH;
            end
            ST_BRANCH: begin
                aluSrcA = 1'b1;
                aluSrcB = ALUB_RT;
                aluFunc = alu_sel;
                pcSrc   = PCSRC_BRANCH;
                isBeq   = (cls_q == CLS_BEQ);
                isBne   = (cls_q == CLS_BNE);
                state_d = ST_FETCH;
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_TRAP;
            end
        endcase
    end

    // Wait counter restarts on every state change and counts unready cycles in memory states.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (wait_state && !memReady) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State, captured instruction fields, counter and sticky status registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            cls_q   <= CLS_INVALID;
            func_q  <= '0;
            cnt_q   <= '0;
            inv_q   <= 1'b0;
            bus_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            func_q  <= func_d;
            cnt_q   <= cnt_d;
            inv_q   <= inv_d;
            bus_q   <= bus_d;
        end
    end

    assign invOpcode = inv_q;
    assign busError  = bus_q;
    assign state     = state_q;

endmodule
